mem_arbiter: RTL and testbench

- Shares the single-port DPI-backed memory between two requesters: instruction fetch (IFU) and load/store unit (LSU).
- Each requester uses a valid/ready request channel and a valid/ready response channel.
- The block serialises one transaction at a time onto the memory port and returns read data or a write acknowledgement to the requester that issued it.
- It sits between the core's IFU/LSU and the memory model, replacing the separate fetch read path with one arbitrated port.

---
 rtl/mem_arbiter_pkg.sv | 25 ++
 rtl/mem_arb_picker.sv | 49 ++++
 rtl/mem_arbiter.sv | 152 +++++++++++++++
 tb/tb_mem_arbiter.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared types and defaults for the IFU/LSU memory arbiter
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } mem_arb_state_e;

    typedef enum logic {
        OWNER_IFU = 1'b0,
        OWNER_LSU = 1'b1
    } mem_arb_owner_e;

    localparam int DEF_ADDR_W      = 32;
    localparam int DEF_DATA_W      = 32;
    localparam int DEF_MEM_LATENCY = 1;

    // Grant vector layout: bit 0 = IFU, bit 1 = LSU.
    function automatic mem_arb_owner_e grant_owner(input logic [1:0] grant);
        return grant[1] ? OWNER_LSU : OWNER_IFU;
    endfunction

endpackage

// File: rtl/mem_arb_picker.sv
// rtl/mem_arb_picker.sv - requester tie-break; round-robin when MEM_ARBITER_RR_EN is defined, else LSU priority
module mem_arb_picker
    import mem_arbiter_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       ifu_valid,
    input  logic       lsu_valid,
    input  logic       fire,
    output logic [1:0] grant
);

`ifdef MEM_ARBITER_RR_EN
    mem_arb_owner_e last_q;

    // Reset value makes the IFU win the first tie.
    always_ff @(posedge clock) begin
        if (!reset) begin
            last_q <= OWNER_LSU;
        end else if (fire) begin
            last_q <= grant_owner(grant);
        end
    end

    always_comb begin
        grant = 2'b00;
        if (ifu_valid && lsu_valid) begin
            grant = (last_q == OWNER_LSU) ? 2'b01 : 2'b10;
        end else if (ifu_valid) begin
            grant = 2'b01;
        end else if (lsu_valid) begin
            grant = 2'b10;
        end
    end
`else
    logic unused_picker;
    assign unused_picker = &{1'b0, clock, reset, fire};

    always_comb begin
        grant = 2'b00;
        if (lsu_valid) begin
            grant = 2'b10;
        end else if (ifu_valid) begin
            grant = 2'b01;
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - serialises IFU and LSU requests onto one memory port; tie policy set by MEM_ARBITER_RR_EN
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int MEM_LATENCY = DEF_MEM_LATENCY
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_req_addr,
    output logic                ifu_resp_valid,
    output logic [DATA_W-1:0]   ifu_resp_data,
    input  logic                ifu_resp_ready,
    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_W-1:0]   lsu_req_addr,
    input  logic                lsu_req_wen,
    input  logic [DATA_W-1:0]   lsu_req_wdata,
    input  logic [DATA_W/8-1:0] lsu_req_wmask,
    output logic                lsu_resp_valid,
    output logic [DATA_W-1:0]   lsu_resp_data,
    input  logic                lsu_resp_ready,
    output logic                mem_valid,
    output logic                mem_write_enable,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int CNT_W  = $clog2(MEM_LATENCY + 1);
    localparam int MASK_W = DATA_W / 8;

    if (MEM_LATENCY < 1) begin : g_latency_check
        $error("mem_arbiter: MEM_LATENCY must be at least 1");
    end

    mem_arb_state_e      state_q;
    mem_arb_state_e      state_d;
    mem_arb_owner_e      owner_q;
    logic                wen_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [MASK_W-1:0]   wmask_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [DATA_W-1:0]   resp_data_q;
    logic [1:0]          grant;
    logic                fire;
    logic                owner_resp_ready;

    // Grants are only offered while idle and out of reset.
    assign fire = reset && (state_q == IDLE) && (grant != 2'b00);
    assign owner_resp_ready = (owner_q == OWNER_LSU) ? lsu_resp_ready : ifu_resp_ready;

    mem_arb_picker u_picker (
        .clock     (clock),
        .reset     (reset),
        .ifu_valid (ifu_req_valid),
        .lsu_valid (lsu_req_valid),
        .fire      (fire),
        .grant     (grant)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (fire) state_d = ISSUE;
            ISSUE: state_d = WAIT;
            WAIT:  if (cnt_q == CNT_W'(1)) state_d = RESP;
            RESP:  if (owner_resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ifu_req_ready    = 1'b0;
        lsu_req_ready    = 1'b0;
        mem_valid        = 1'b0;
        mem_write_enable = 1'b0;
        ifu_resp_valid   = 1'b0;
        lsu_resp_valid   = 1'b0;
        case (state_q)
            IDLE: begin
                ifu_req_ready = reset && grant[0];
                lsu_req_ready = reset && grant[1];
            end
            ISSUE: begin
                mem_valid        = 1'b1;
                mem_write_enable = wen_q;
            end
            RESP: begin
                ifu_resp_valid = (owner_q == OWNER_IFU);
                lsu_resp_valid = (owner_q == OWNER_LSU);
            end
            default: ;
        endcase
    end

    // Request latch, latency counter and response register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            owner_q     <= OWNER_IFU;
            wen_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wmask_q     <= '0;
            cnt_q       <= '0;
            resp_data_q <= '0;
        end else begin
            if (fire) begin
                owner_q <= grant_owner(grant);
                if (grant[1]) begin
                    wen_q   <= lsu_req_wen;
                    addr_q  <= lsu_req_addr;
                    wdata_q <= lsu_req_wdata;
                    wmask_q <= lsu_req_wmask;
                end else begin
                    wen_q   <= 1'b0;
                    addr_q  <= ifu_req_addr;
                    wdata_q <= '0;
                    wmask_q <= '0;
                end
            end
            if (state_q == ISSUE) begin
                cnt_q <= CNT_W'(MEM_LATENCY);
            end else if (state_q == WAIT && cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
            end
            if (state_q == WAIT && cnt_q == CNT_W'(1)) begin
                resp_data_q <= wen_q ? '0 : mem_rdata;
            end
        end
    end

    assign mem_addr      = addr_q;
    assign mem_wdata     = wdata_q;
    assign mem_wmask     = wmask_q;
    assign ifu_resp_data = resp_data_q;
    assign lsu_resp_data = resp_data_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter; tie expectations follow MEM_ARBITER_RR_EN
module tb_mem_arbiter;

    localparam int LAT = 1;
`ifdef MEM_ARBITER_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_ready;
    logic [31:0] ifu_req_addr, ifu_resp_data;
    logic        lsu_req_valid, lsu_req_ready, lsu_req_wen, lsu_resp_valid, lsu_resp_ready;
    logic [31:0] lsu_req_addr, lsu_req_wdata, lsu_resp_data;
    logic [3:0]  lsu_req_wmask;
    logic        mem_valid, mem_write_enable;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wmask;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(LAT)) dut (
        .clock(clock), .reset(reset),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_resp_data(ifu_resp_data), .ifu_resp_ready(ifu_resp_ready),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_addr(lsu_req_addr),
        .lsu_req_wen(lsu_req_wen), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
        .lsu_resp_valid(lsu_resp_valid), .lsu_resp_data(lsu_resp_data), .lsu_resp_ready(lsu_resp_ready),
        .mem_valid(mem_valid), .mem_write_enable(mem_write_enable), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rdata(mem_rdata)
    );

    function automatic logic [31:0] init_word(input logic [31:0] a);
        if (a == 32'h8000_0000) return 32'h0000_0413;
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] wm);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (wm[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    // Memory device attached to the port: applies stores, returns loads LAT cycles after issue.
    logic [31:0] mem_store [logic [31:0]];
    logic [31:0] rd_pipe [LAT];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return mem_store.exists(a) ? mem_store[a] : init_word(a);
    endfunction

    always @(posedge clock) begin
        if (mem_valid && mem_write_enable) mem_store[mem_addr] = merge(mem_word(mem_addr), mem_wdata, mem_wmask);
        rd_pipe[0] <= (mem_valid && !mem_write_enable) ? mem_word(mem_addr) : $urandom;
        for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rdata = rd_pipe[LAT-1];

    // Reference memory: the architectural contents the requesters should observe.
    logic [31:0] ref_mem [logic [31:0]];
    function automatic logic [31:0] ref_word(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    int          o_hs, o_iss, o_iss_n, o_we_n, o_resp;
    logic [31:0] o_addr, o_wdata, o_rdata, o_exp;
    logic [3:0]  o_wmask;
    bit          o_other, o_stable;

    task automatic xact(input bit lsu, input bit wen, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wmask, input int hold);
        bit done = 0;
        int held = 0;
        logic [31:0] cur;
        o_hs = -1; o_iss = -1; o_iss_n = 0; o_we_n = 0; o_resp = -1;
        o_other = 0; o_stable = 1; o_rdata = 'x; o_addr = 'x; o_wdata = 'x; o_wmask = 'x;
        @(posedge clock); #1;
        if (lsu) begin
            lsu_req_valid = 1; lsu_req_addr = addr; lsu_req_wen = wen;
            lsu_req_wdata = wdata; lsu_req_wmask = wmask;
        end else begin
            ifu_req_valid = 1; ifu_req_addr = addr;
        end
        ifu_resp_ready = (hold == 0);
        lsu_resp_ready = (hold == 0);
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if ((lsu ? lsu_req_ready : ifu_req_ready) === 1'b1) begin o_hs = cyc; break; end
        end
        o_exp = (lsu && wen) ? 32'h0 : ref_word(addr);
        if (lsu && wen) ref_mem[addr] = merge(ref_word(addr), wdata, wmask);
        @(posedge clock); #1;
        ifu_req_valid = 0; lsu_req_valid = 0;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clock);
            if (mem_valid) begin
                o_iss_n++;
                if (o_iss < 0) begin o_iss = cyc; o_addr = mem_addr; o_wdata = mem_wdata; o_wmask = mem_wmask; end
            end
            if (mem_write_enable) o_we_n++;
            if (lsu ? ifu_resp_valid : lsu_resp_valid) o_other = 1;
            if (lsu ? lsu_resp_valid : ifu_resp_valid) begin
                cur = lsu ? lsu_resp_data : ifu_resp_data;
                if (o_resp < 0) begin o_resp = cyc; o_rdata = cur; end
                else if (cur !== o_rdata) o_stable = 0;
                if (lsu ? lsu_resp_ready : ifu_resp_ready) done = 1;
                else begin
                    held++;
                    if (held >= hold) begin @(posedge clock); #1; ifu_resp_ready = 1; lsu_resp_ready = 1; end
                end
            end
        end
        @(posedge clock); #1;
        ifu_resp_ready = 1; lsu_resp_ready = 1;
    endtask

    task automatic test_reset();
        reset = 0; ifu_req_valid = 1; lsu_req_valid = 1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        n_checks++;
        if ({ifu_req_ready, lsu_req_ready} !== 2'b00) begin
            n_fail++; $display("FAIL reset_req_ready: got %b expected 00", {ifu_req_ready, lsu_req_ready});
        end
        n_checks++;
        if ({ifu_resp_valid, lsu_resp_valid, mem_valid, mem_write_enable} !== 4'b0) begin
            n_fail++; $display("FAIL reset_valids: got %b expected 0000",
                               {ifu_resp_valid, lsu_resp_valid, mem_valid, mem_write_enable});
        end
        n_checks++;
        if ({mem_addr, mem_wdata, mem_wmask, ifu_resp_data, lsu_resp_data} !== '0) begin
            n_fail++; $display("FAIL reset_data: got %h %h %h %h %h expected all 0",
                               mem_addr, mem_wdata, mem_wmask, ifu_resp_data, lsu_resp_data);
        end
        @(posedge clock); #1;
        ifu_req_valid = 0; lsu_req_valid = 0; reset = 1;
        @(negedge clock);
        n_checks++;
        if ({ifu_req_ready, lsu_req_ready, mem_valid} !== 3'b0) begin
            n_fail++; $display("FAIL idle_after_reset: got %b expected 000", {ifu_req_ready, lsu_req_ready, mem_valid});
        end
    endtask

    task automatic test_ifu_read();
        xact(0, 0, 32'h8000_0000, 32'h0, 4'h0, 0);
        n_checks++;
        if (o_iss !== o_hs + 1 || o_iss_n !== 1 || o_hs < 0) begin
            n_fail++; $display("FAIL ifu_issue_cycle: got hs=%0d issue=%0d n=%0d expected issue=hs+1 n=1", o_hs, o_iss, o_iss_n);
        end
        n_checks++;
        if (o_addr !== 32'h8000_0000 || o_we_n !== 0) begin
            n_fail++; $display("FAIL ifu_issue_fields: got addr=%h we=%0d expected 80000000 0", o_addr, o_we_n);
        end
        n_checks++;
        if (o_resp !== o_hs + 2 + LAT) begin
            n_fail++; $display("FAIL ifu_resp_cycle: got %0d expected %0d", o_resp, o_hs + 2 + LAT);
        end
        n_checks++;
        if (o_rdata !== 32'h0000_0413 || o_other) begin
            n_fail++; $display("FAIL ifu_resp_data: got %h other=%0d expected 00000413 other=0", o_rdata, o_other);
        end
    endtask

    task automatic test_lsu_store();
        xact(1, 1, 32'h8000_0100, 32'hDEAD_BEEF, 4'hF, 0);
        n_checks++;
        if (o_we_n !== 1 || o_iss !== o_hs + 1 || o_iss_n !== 1) begin
            n_fail++; $display("FAIL store_issue: got we=%0d issue=%0d hs=%0d expected we=1 issue=hs+1", o_we_n, o_iss, o_hs);
        end
        n_checks++;
        if (o_addr !== 32'h8000_0100 || o_wdata !== 32'hDEAD_BEEF || o_wmask !== 4'hF) begin
            n_fail++; $display("FAIL store_fields: got %h %h %h expected 80000100 deadbeef f", o_addr, o_wdata, o_wmask);
        end
        n_checks++;
        if (o_rdata !== 32'h0 || o_resp !== o_hs + 2 + LAT || o_other) begin
            n_fail++; $display("FAIL store_ack: got data=%h cyc=%0d other=%0d expected 0 %0d 0", o_rdata, o_resp, o_other, o_hs + 2 + LAT);
        end
        xact(1, 0, 32'h8000_0100, 32'h0, 4'h0, 0);
        n_checks++;
        if (o_rdata !== 32'hDEAD_BEEF || o_we_n !== 0) begin
            n_fail++; $display("FAIL load_after_store: got %h we=%0d expected deadbeef 0", o_rdata, o_we_n);
        end
        xact(1, 1, 32'h8000_0100, 32'h1122_3344, 4'b0101, 0);
        xact(1, 0, 32'h8000_0100, 32'h0, 4'h0, 0);
        n_checks++;
        if (o_rdata !== 32'hDE22_BE44) begin
            n_fail++; $display("FAIL partial_store: got %h expected de22be44", o_rdata);
        end
    endtask

    task automatic test_arbitration();
        bit last_lsu = 1, exp_lsu, both = 0;
        int grants = 0, n_resp = 0;
        reset = 0;
        repeat (2) @(posedge clock);
        #1; reset = 1;
        ifu_req_addr = 32'h8000_0000; lsu_req_addr = 32'h8000_0104; lsu_req_wen = 0;
        ifu_req_valid = 1; lsu_req_valid = 1; ifu_resp_ready = 1; lsu_resp_ready = 1;
        for (int k = 0; k < 200 && grants < 4; k++) begin
            @(negedge clock);
            if (ifu_resp_valid || lsu_resp_valid) begin
                n_resp++;
                n_checks++;
                if ((ifu_resp_valid ? ifu_resp_data : lsu_resp_data) !== ref_word(ifu_resp_valid ? ifu_req_addr : lsu_req_addr)) begin
                    n_fail++; $display("FAIL arb_resp_data: got %h", ifu_resp_valid ? ifu_resp_data : lsu_resp_data);
                end
            end
            if (ifu_req_ready && lsu_req_ready) both = 1;
            if (ifu_req_ready || lsu_req_ready) begin
                exp_lsu = RR_EN ? !last_lsu : 1'b1;
                n_checks++;
                if (lsu_req_ready !== exp_lsu) begin
                    n_fail++; $display("FAIL arb_grant%0d: got lsu=%0d expected lsu=%0d", grants, lsu_req_ready, exp_lsu);
                end
                last_lsu = exp_lsu;
                grants++;
            end
        end
        @(posedge clock); #1;
        ifu_req_valid = 0; lsu_req_valid = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if (ifu_resp_valid || lsu_resp_valid) n_resp++;
        end
        n_checks++;
        if (grants !== 4 || n_resp !== 4 || both) begin
            n_fail++; $display("FAIL arb_totals: got grants=%0d resps=%0d both=%0d expected 4 4 0", grants, n_resp, both);
        end
    endtask

    task automatic test_backpressure();
        int hs = -1, first = -1, r = -1, iresp = -1;
        logic [31:0] d0 = 'x, idata = 'x;
        bit stable = 1, ifu_seen = 0, ifu_granted;
        @(posedge clock); #1;
        lsu_req_valid = 1; lsu_req_addr = 32'h8000_0108; lsu_req_wen = 0; lsu_resp_ready = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if (lsu_req_ready === 1'b1) begin hs = cyc; break; end
        end
        @(posedge clock); #1;
        lsu_req_valid = 0; ifu_req_valid = 1; ifu_req_addr = 32'h8000_0004;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if (ifu_req_ready) ifu_seen = 1;
            if (lsu_resp_valid === 1'b1) begin first = cyc; d0 = lsu_resp_data; break; end
        end
        for (int k = 1; k < 5; k++) begin
            @(negedge clock);
            if (lsu_resp_valid !== 1'b1 || lsu_resp_data !== d0) stable = 0;
            if (ifu_req_ready) ifu_seen = 1;
        end
        @(posedge clock); #1;
        lsu_resp_ready = 1;
        @(negedge clock);
        r = cyc;
        if (lsu_resp_valid !== 1'b1 || lsu_resp_data !== d0) stable = 0;
        if (ifu_req_ready) ifu_seen = 1;
        @(negedge clock);
        ifu_granted = (ifu_req_ready === 1'b1) && (cyc == r + 1);
        @(posedge clock); #1;
        ifu_req_valid = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if (ifu_resp_valid === 1'b1) begin iresp = cyc; idata = ifu_resp_data; break; end
        end
        n_checks++;
        if (first !== hs + 2 + LAT || d0 !== ref_word(32'h8000_0108)) begin
            n_fail++; $display("FAIL bp_lsu_resp: got cyc=%0d data=%h expected %0d %h", first, d0, hs + 2 + LAT, ref_word(32'h8000_0108));
        end
        n_checks++;
        if (!stable || ifu_seen) begin
            n_fail++; $display("FAIL bp_hold: got stable=%0d ifu_ready_seen=%0d expected 1 0", stable, ifu_seen);
        end
        n_checks++;
        if (!ifu_granted) begin
            n_fail++; $display("FAIL bp_ifu_grant: got ifu_req_ready=%0d in cycle r+1 expected 1", ifu_granted);
        end
        n_checks++;
        if (iresp !== r + 1 + 2 + LAT || idata !== ref_word(32'h8000_0004)) begin
            n_fail++; $display("FAIL bp_ifu_resp: got cyc=%0d data=%h expected %0d %h", iresp, idata, r + 3 + LAT, ref_word(32'h8000_0004));
        end
    endtask

    task automatic test_reset_mid();
        int hs = -1;
        bit resp_seen = 0;
        @(posedge clock); #1;
        ifu_req_valid = 1; ifu_req_addr = 32'h8000_0000;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if (ifu_req_ready === 1'b1) begin hs = cyc; break; end
        end
        @(posedge clock); #1;
        ifu_req_valid = 0;
        @(posedge clock); #1;
        reset = 0;
        @(posedge clock); #1;
        reset = 1;
        @(negedge clock);
        n_checks++;
        if ({ifu_req_ready, lsu_req_ready, ifu_resp_valid, lsu_resp_valid, mem_valid, mem_write_enable,
             mem_addr, mem_wdata, mem_wmask, ifu_resp_data} !== '0 || hs < 0) begin
            n_fail++; $display("FAIL midreset_outputs: got addr=%h resp_valid=%0d data=%h hs=%0d expected all 0",
                               mem_addr, ifu_resp_valid, ifu_resp_data, hs);
        end
        for (int k = 0; k < 2 * LAT + 4; k++) begin
            @(negedge clock);
            if (ifu_resp_valid || lsu_resp_valid) resp_seen = 1;
        end
        n_checks++;
        if (resp_seen) begin
            n_fail++; $display("FAIL midreset_no_resp: got response after reset expected none");
        end
        xact(0, 0, 32'h8000_0000, 32'h0, 4'h0, 0);
        n_checks++;
        if (o_rdata !== 32'h0000_0413 || o_resp !== o_hs + 2 + LAT) begin
            n_fail++; $display("FAIL midreset_fresh: got %h cyc=%0d expected 00000413 %0d", o_rdata, o_resp, o_hs + 2 + LAT);
        end
    endtask

    task automatic test_random();
        bit lsu, wen;
        logic [31:0] addr;
        for (int t = 0; t < 16; t++) begin
            lsu  = 1'($urandom_range(0, 1));
            wen  = lsu && 1'($urandom_range(0, 1));
            addr = 32'h8000_0200 + 32'(4 * $urandom_range(0, 3));
            xact(lsu, wen, addr, $urandom, 4'($urandom_range(1, 15)), $urandom_range(0, 3));
            n_checks++;
            if (o_rdata !== o_exp || !o_stable || o_other) begin
                n_fail++; $display("FAIL rand%0d_data: got %h stable=%0d other=%0d expected %h", t, o_rdata, o_stable, o_other, o_exp);
            end
            n_checks++;
            if (o_iss !== o_hs + 1 || o_resp !== o_hs + 2 + LAT || o_we_n !== int'(wen) || o_addr !== addr) begin
                n_fail++; $display("FAIL rand%0d_timing: got hs=%0d iss=%0d resp=%0d we=%0d addr=%h expected iss=hs+1 resp=hs+%0d we=%0d addr=%h",
                                   t, o_hs, o_iss, o_resp, o_we_n, o_addr, 2 + LAT, wen, addr);
            end
        end
    endtask

    initial begin
        reset = 0;
        ifu_req_valid = 0; ifu_req_addr = 0; ifu_resp_ready = 1;
        lsu_req_valid = 0; lsu_req_addr = 0; lsu_req_wen = 0; lsu_req_wdata = 0; lsu_req_wmask = 0;
        lsu_resp_ready = 1;
        test_reset();
        test_ifu_read();
        test_lsu_store();
        test_arbitration();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
